// File: rtl/sisc_pkg.sv
// Shared sisc definitions: frame header byte, loader state encoding,
// and the address/count widths used by pc, im and the loader.
package sisc_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         ADDR_W   = 16;
    localparam int         CNT_W    = 16;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_ADDR_HI = 3'd1,
        LD_ADDR_LO = 3'd2,
        LD_CNT_HI  = 3'd3,
        LD_CNT_LO  = 3'd4,
        LD_DATA    = 3'd5,
        LD_WRITE   = 3'd6,
        LD_CSUM    = 3'd7
    } ld_state_t;

endpackage

// File: rtl/im_word_asm.sv
// 4-byte MSB-first word assembler.
// Ports: clk, rst_f (async active-low), clr (restart), shift (take din),
//        din (byte), word (assembled word incl. din), full (din is 4th byte).
module im_word_asm (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        full
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[15:0], din};
            cnt <= cnt + 2'd1;
        end
    end

    // The 4th byte is not stored; it is combined here so the
    // word is ready on the same edge that accepts it.
    assign word = {sr, din};
    assign full = shift && (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: framed byte stream -> 32-bit im writes.
// Ports: CLK, RST_F (async active-low), IN_DATA/IN_VALID/IN_READY (byte
//        stream), IM_WE/IM_WADDR/IM_WDATA (im write port), CPU_RST_F
//        (core reset, active-low), DONE/ERR (sticky frame status).
module im_loader
    import sisc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_F,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              IM_WE,
    output logic [ADDR_W-1:0] IM_WADDR,
    output logic [31:0]       IM_WDATA,
    output logic              CPU_RST_F,
    output logic              DONE,
    output logic              ERR
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [31:0]       wdata_d;
    logic              we_d, done_d, err_d;
    logic              ready_d, cpu_d;
    logic              acc, clr, shift;
    logic [31:0]       word;
    logic              full;
    logic [CNT_W-1:0]  cnt_new;

    assign acc     = IN_VALID && IN_READY;
    assign cnt_new = {cnt_q[15:8], IN_DATA};

    im_word_asm u_asm (
        .clk   (CLK),
        .rst_f (RST_F),
        .clr   (clr),
        .shift (shift),
        .din   (IN_DATA),
        .word  (word),
        .full  (full)
    );

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q   <= LD_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            IN_READY  <= 1'b1;
            IM_WE     <= 1'b0;
            IM_WADDR  <= '0;
            IM_WDATA  <= '0;
            CPU_RST_F <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            IN_READY  <= ready_d;
            IM_WE     <= we_d;
            IM_WADDR  <= waddr_d;
            IM_WDATA  <= wdata_d;
            CPU_RST_F <= cpu_d;
            DONE      <= done_d;
            ERR       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = IM_WADDR;
        wdata_d = IM_WDATA;
        done_d  = DONE;
        err_d   = ERR;
        clr     = 1'b0;
        shift   = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (acc && IN_DATA == HDR_BYTE) begin
                    state_d = LD_ADDR_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    csum_d  = '0;
                    clr     = 1'b1;
                end
            end
            LD_ADDR_HI: begin
                if (acc) begin
                    addr_d  = {IN_DATA, addr_q[7:0]};
                    csum_d  = csum_q ^ IN_DATA;
                    state_d = LD_ADDR_LO;
                end
            end
            LD_ADDR_LO: begin
                if (acc) begin
                    addr_d  = {addr_q[15:8], IN_DATA};
                    csum_d  = csum_q ^ IN_DATA;
                    state_d = LD_CNT_HI;
                end
            end
            LD_CNT_HI: begin
                if (acc) begin
                    cnt_d   = {IN_DATA, cnt_q[7:0]};
                    csum_d  = csum_q ^ IN_DATA;
                    state_d = LD_CNT_LO;
                end
            end
            LD_CNT_LO: begin
                if (acc) begin
                    cnt_d   = cnt_new;
                    csum_d  = csum_q ^ IN_DATA;
                    state_d = (cnt_new != '0) ? LD_DATA : LD_CSUM;
                end
            end
            LD_DATA: begin
                if (acc) begin
                    shift  = 1'b1;
                    csum_d = csum_q ^ IN_DATA;
                    if (full) begin
                        state_d = LD_WRITE;
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word;
                    end
                end
            end
            LD_WRITE: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? LD_CSUM : LD_DATA;
            end
            LD_CSUM: begin
                if (acc) begin
                    state_d = LD_IDLE;
                    if (IN_DATA == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                end
            end
            default: state_d = LD_IDLE;
        endcase

        // Registered outputs track the state being entered.
        ready_d = (state_d != LD_WRITE);
        cpu_d   = (state_d == LD_IDLE) && !err_d;
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as frames
// are driven and compared when IM_WE pulses.
module tb_im_loader;

    logic        CLK = 1'b0;
    logic        RST_F = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        IM_WE;
    logic [15:0] IM_WADDR;
    logic [31:0] IM_WDATA;
    logic        CPU_RST_F;
    logic        DONE;
    logic        ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int we_count = 0;
    int rdy_low  = 0;
    logic [47:0] sb[$];
    int we_cyc[$];
    logic [31:0] wbuf[0:7];

    im_loader dut (
        .CLK       (CLK),
        .RST_F     (RST_F),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IM_WE     (IM_WE),
        .IM_WADDR  (IM_WADDR),
        .IM_WDATA  (IM_WDATA),
        .CPU_RST_F (CPU_RST_F),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!IN_READY) rdy_low++;
        if (IM_WE) begin
            logic [47:0] e;
            we_count++;
            we_cyc.push_back(cyc);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         IM_WADDR, IM_WDATA);
            end else begin
                e = sb.pop_front();
                if ({IM_WADDR, IM_WDATA} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             IM_WADDR, IM_WDATA, e[47:32], e[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit ok;
        ok = 1'b0;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        for (int n = 0; n < 20; n++) begin
            r = IN_READY;
            @(posedge CLK);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, required accept in 20 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                              input logic [7:0] bad);
        logic [7:0]  c;
        logic [15:0] wa;
        logic [31:0] w;
        c = a[15:8] ^ a[7:0] ^ n[15:8] ^ n[7:0];
        send_byte(8'hA5);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        wa = a;
        for (int i = 0; i < int'(n); i++) begin
            w = wbuf[i];
            c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            sb.push_back({wa, w});
            send_byte(w[7:0]);
            wa = wa + 16'd1;
        end
        send_byte(c ^ bad);
    endtask

    task automatic check_status(input string nm, input logic d, input logic e,
                                input logic c);
        n_checks++;
        if ({DONE, ERR, CPU_RST_F} !== {d, e, c}) begin
            n_fail++;
            $display("FAIL %s: got done/err/cpu=%b%b%b, required %b%b%b",
                     nm, DONE, ERR, CPU_RST_F, d, e, c);
        end
    endtask

    task automatic check_sb_empty(input string nm);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d writes missing, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({IN_READY, IM_WE, IM_WADDR, IM_WDATA, DONE, ERR, CPU_RST_F} !==
            {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b we=%b wa=%h wd=%h done=%b err=%b cpu=%b, required 1 0 0 0 0 0 0",
                     IN_READY, IM_WE, IM_WADDR, IM_WDATA, DONE, ERR, CPU_RST_F);
        end
        #2 RST_F = 1'b1;
        @(posedge CLK);
        #1;
        check_status("reset_release", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single_word;
        wbuf[0] = 32'hDEADBEEF;
        send_frame(16'h0010, 16'd1, 8'h00);
        check_status("single_done", 1'b1, 1'b0, 1'b1);
        idle(2);
        check_sb_empty("single_writes");
    endtask

    task automatic test_addr_wrap;
        wbuf[0] = 32'h11111111;
        wbuf[1] = 32'h22222222;
        rdy_low = 0;
        send_frame(16'hFFFF, 16'd2, 8'h00);
        idle(2);
        n_checks++;
        if (rdy_low != 2) begin
            n_fail++;
            $display("FAIL wrap_ready_low: got %0d cycles, required 2", rdy_low);
        end
        check_status("wrap_done", 1'b1, 1'b0, 1'b1);
        check_sb_empty("wrap_writes");
    endtask

    task automatic test_bad_csum;
        int w0;
        wbuf[0] = 32'hDEADBEEF;
        w0 = we_count;
        send_frame(16'h0010, 16'd1, 8'h01);
        check_status("bad_err", 1'b0, 1'b1, 1'b0);
        idle(4);
        check_status("bad_sticky", 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (we_count != w0 + 1) begin
            n_fail++;
            $display("FAIL bad_write_kept: got %0d writes, required 1", we_count - w0);
        end
        check_sb_empty("bad_writes");
    endtask

    task automatic test_zero_junk;
        int w0;
        w0 = we_count;
        send_byte(8'h00);
        send_byte(8'h7F);
        check_status("junk_ignored", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5);
        check_status("hdr_clears", 1'b0, 1'b0, 1'b0);
        repeat (5) send_byte(8'h00);
        check_status("zero_done", 1'b1, 1'b0, 1'b1);
        idle(3);
        n_checks++;
        if (we_count != w0) begin
            n_fail++;
            $display("FAIL zero_no_write: got %0d writes, required 0", we_count - w0);
        end
    endtask

    task automatic test_reset_mid;
        int w0;
        w0 = we_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        IN_VALID = 1'b0;
        RST_F = 1'b0;
        #1;
        n_checks++;
        if ({IN_READY, IM_WE, IM_WADDR, DONE, ERR, CPU_RST_F} !==
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b we=%b wa=%h done=%b err=%b cpu=%b, required 1 0 0 0 0 0",
                     IN_READY, IM_WE, IM_WADDR, DONE, ERR, CPU_RST_F);
        end
        @(posedge CLK);
        #2 RST_F = 1'b1;
        idle(3);
        n_checks++;
        if (we_count != w0) begin
            n_fail++;
            $display("FAIL midreset_no_write: got %0d writes, required 0", we_count - w0);
        end
        wbuf[0] = 32'hCAFEF00D;
        send_frame(16'h0020, 16'd1, 8'h00);
        check_status("midreset_reload", 1'b1, 1'b0, 1'b1);
        idle(2);
        check_sb_empty("midreset_writes");
    endtask

    task automatic test_back_to_back;
        int c0;
        int c1;
        wbuf[0] = 32'h01020304;
        wbuf[1] = 32'h05060708;
        wbuf[2] = 32'h090A0B0C;
        we_cyc.delete();
        c0 = cyc;
        send_frame(16'h0100, 16'd3, 8'h00);
        c1 = cyc;
        check_status("b2b_done", 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (c1 - c0 != 21) begin
            n_fail++;
            $display("FAIL b2b_frame_time: got %0d cycles, required 21", c1 - c0);
        end
        idle(2);
        n_checks++;
        if (we_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d, required 3", we_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (we_cyc[i] - we_cyc[i-1] != 5) begin
                    n_fail++;
                    $display("FAIL b2b_word_spacing: got %0d cycles, required 5",
                             we_cyc[i] - we_cyc[i-1]);
                end
            end
        end
        check_sb_empty("b2b_writes");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_addr_wrap();
        test_bad_csum();
        test_zero_junk();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
